// File: rtl/match_pkg.sv
// Shared match-level types and constants for the pong sequencer.
// Screen geometry mirrors the vga/sprite definitions used by game_logic.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } match_state_t;

  localparam int unsigned WIN_SCORE_DEF    = 9;
  localparam int unsigned SERVE_FRAMES_DEF = 90;
  localparam int unsigned SCORE_W_DEF      = 4;

  localparam int unsigned X_POS_W       = 10;
  localparam int unsigned SCREEN_H_RES  = 640;
  localparam int unsigned SCREEN_BORDER = 8;

endpackage

// File: rtl/key_edge.sv
// Registers a debounced key level once and emits a 1-cycle pulse on its rising edge.
module key_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_c_o
);

  logic key_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) key_q <= 1'b0;
    else         key_q <= key_i;
  end

  assign press_c_o = key_i & ~key_q;

endmodule

// File: rtl/match_controller.sv
// Match-level sequencer for pong: serve timing, exit detection, scoring and
// run/respawn gating of game_logic.
module match_controller
  import match_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int unsigned SCORE_W      = SCORE_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               new_frame_i,
  input  logic               start_key_i,
  input  logic               pause_key_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  output logic               run_o,
  output logic               ball_reset_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] player_score_o,
  output logic [SCORE_W-1:0] enemy_score_o,
  output logic               game_over_o,
  output logic               winner_o,
  output logic [2:0]         state_o
);

  localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  logic start_press, pause_press;

  match_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] pscore_q, pscore_d, escore_q, escore_d;
  logic [SCORE_W-1:0] pscore_inc, escore_inc;
  logic               dir_q, dir_d;
  logic               scorer_q, scorer_d;
  logic               winner_q, winner_d;
  logic               run_q, run_d;
  logic               brst_q, brst_d;
  logic               over_q, over_d;
  logic               exit_right, exit_left;

  key_edge u_start_edge (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .key_i    (start_key_i),
    .press_c_o(start_press)
  );

  key_edge u_pause_edge (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .key_i    (pause_key_i),
    .press_c_o(pause_press)
  );

  assign exit_right = ball_x_i > X_POS_W'(SCREEN_H_RES);
  assign exit_left  = ball_x_i < X_POS_W'(SCREEN_BORDER);

  // Saturating increments; only one of them is committed in POINT.
  assign pscore_inc = (pscore_q >= WIN_VAL) ? pscore_q : pscore_q + SCORE_W'(1);
  assign escore_inc = (escore_q >= WIN_VAL) ? escore_q : escore_q + SCORE_W'(1);

  // State and datapath registers; Moore outputs track the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pscore_q <= '0;
      escore_q <= '0;
      dir_q    <= 1'b0;
      scorer_q <= 1'b0;
      winner_q <= 1'b0;
      run_q    <= 1'b0;
      brst_q   <= 1'b1;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pscore_q <= pscore_d;
      escore_q <= escore_d;
      dir_q    <= dir_d;
      scorer_q <= scorer_d;
      winner_q <= winner_d;
      run_q    <= run_d;
      brst_q   <= brst_d;
      over_q   <= over_d;
    end
  end

  // Next-state and score/serve bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pscore_d = pscore_q;
    escore_d = escore_q;
    dir_d    = dir_q;
    scorer_d = scorer_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        if (start_press) begin
          state_d = SERVE;
          cnt_d   = SERVE_LOAD;
        end
      end
      SERVE: begin
        if (new_frame_i) begin
          if (cnt_q == '0) state_d = PLAY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      PLAY: begin
        // A frame-aligned exit wins over a pause press in the same cycle.
        if (new_frame_i && exit_right) begin
          state_d  = POINT;
          scorer_d = 1'b1;
        end else if (new_frame_i && exit_left) begin
          state_d  = POINT;
          scorer_d = 1'b0;
        end else if (pause_press) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_press) state_d = PLAY;
      end
      POINT: begin
        // Serve goes towards whoever conceded the point.
        if (scorer_q) begin
          escore_d = escore_inc;
          dir_d    = 1'b1;
          if (escore_inc == WIN_VAL) begin
            state_d  = OVER;
            winner_d = 1'b1;
          end else begin
            state_d = SERVE;
            cnt_d   = SERVE_LOAD;
          end
        end else begin
          pscore_d = pscore_inc;
          dir_d    = 1'b0;
          if (pscore_inc == WIN_VAL) begin
            state_d  = OVER;
            winner_d = 1'b0;
          end else begin
            state_d = SERVE;
            cnt_d   = SERVE_LOAD;
          end
        end
      end
      OVER: begin
        if (start_press) begin
          state_d  = SERVE;
          cnt_d    = SERVE_LOAD;
          pscore_d = '0;
          escore_d = '0;
          dir_d    = 1'b0;
          winner_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state.
  always_comb begin
    run_d  = 1'b0;
    brst_d = 1'b1;
    over_d = 1'b0;
    case (state_d)
      PLAY: begin
        run_d  = 1'b1;
        brst_d = 1'b0;
      end
      PAUSE:   brst_d = 1'b0;
      OVER:    over_d = 1'b1;
      default: ;
    endcase
  end

  assign run_o          = run_q;
  assign ball_reset_o   = brst_q;
  assign serve_dir_o    = dir_q;
  assign player_score_o = pscore_q;
  assign enemy_score_o  = escore_q;
  assign game_over_o    = over_q;
  assign winner_o       = winner_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller with SERVE_FRAMES=3, WIN_SCORE=2.
module tb_match_controller;
  import match_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       run;
    logic       brst;
    logic [3:0] ps;
    logic [3:0] es;
    logic       dir;
    logic       over;
    logic       win;
  } out_t;

  typedef struct packed {
    logic       start;
    logic       pause;
    logic       frame;
    logic [9:0] x;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       new_frame_i, start_key_i, pause_key_i;
  logic [9:0] ball_x_i;
  logic       run_o, ball_reset_o, serve_dir_o, game_over_o, winner_o;
  logic [3:0] player_score_o, enemy_score_o;
  logic [2:0] state_o;

  int   n_vec = 0;
  int   n_bad = 0;
  out_t exp_q[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  match_controller #(.WIN_SCORE(2), .SERVE_FRAMES(3), .SCORE_W(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .new_frame_i   (new_frame_i),
    .start_key_i   (start_key_i),
    .pause_key_i   (pause_key_i),
    .ball_x_i      (ball_x_i),
    .run_o         (run_o),
    .ball_reset_o  (ball_reset_o),
    .serve_dir_o   (serve_dir_o),
    .player_score_o(player_score_o),
    .enemy_score_o (enemy_score_o),
    .game_over_o   (game_over_o),
    .winner_o      (winner_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  function automatic out_t ex(match_state_t st, int ps, int es, bit dir, bit win);
    out_t o;
    o.st   = st;
    o.run  = (st == PLAY);
    o.brst = !(st == PLAY || st == PAUSE);
    o.ps   = 4'(ps);
    o.es   = 4'(es);
    o.dir  = dir;
    o.over = (st == OVER);
    o.win  = win;
    return o;
  endfunction

  function automatic vec_t mk(bit s, bit p, bit f, int x, out_t e);
    vec_t v;
    v.start = s;
    v.pause = p;
    v.frame = f;
    v.x     = 10'(x);
    v.exp   = e;
    return v;
  endfunction

  task automatic check(input string name, input out_t e);
    out_t a;
    a = {state_o, run_o, ball_reset_o, player_score_o, enemy_score_o,
         serve_dir_o, game_over_o, winner_o};
    if (!e.over) a.win = e.win;  // winner only meaningful in OVER
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got st=%0d run=%0b brst=%0b ps=%0d es=%0d dir=%0b over=%0b win=%0b; want st=%0d run=%0b brst=%0b ps=%0d es=%0d dir=%0b over=%0b win=%0b",
               name, a.st, a.run, a.brst, a.ps, a.es, a.dir, a.over, a.win,
               e.st, e.run, e.brst, e.ps, e.es, e.dir, e.over, e.win);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    start_key_i = v.start;
    pause_key_i = v.pause;
    new_frame_i = v.frame;
    ball_x_i    = v.x;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(name, exp_q.pop_front());
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    start_key_i = 1'b0;
    pause_key_i = 1'b0;
    new_frame_i = 1'b0;
    ball_x_i    = 10'd320;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    int serve_entries;
    logic [2:0] prev_st;

    // Main sequence: serve, edge-of-screen boundaries, points, win, pause.
    tbl_a.push_back(mk(1, 0, 0, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(1, 0, 1, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 0, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(PLAY,  0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 0, 641, ex(PLAY,  0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 640, ex(PLAY,  0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 8,   ex(PLAY,  0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 641, ex(POINT, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 0, 320, ex(SERVE, 0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(PLAY,  0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 1, 7,   ex(POINT, 0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 0, 320, ex(SERVE, 1, 1, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 1, 1, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 1, 1, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(PLAY,  1, 1, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 7,   ex(POINT, 1, 1, 0, 0)));
    tbl_a.push_back(mk(0, 0, 0, 320, ex(OVER,  2, 1, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(OVER,  2, 1, 0, 0)));
    tbl_a.push_back(mk(1, 0, 0, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(PLAY,  0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 1, 0, 320, ex(PAUSE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 1, 1, 641, ex(PAUSE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(1, 0, 0, 320, ex(PAUSE, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 1, 0, 320, ex(PLAY,  0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 0, 320, ex(PLAY,  0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 1, 1, 641, ex(POINT, 0, 0, 0, 0)));
    tbl_a.push_back(mk(0, 0, 0, 320, ex(SERVE, 0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(PLAY,  0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 1, 7,   ex(POINT, 0, 1, 1, 0)));
    tbl_a.push_back(mk(0, 0, 0, 320, ex(SERVE, 1, 1, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 1, 1, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(SERVE, 1, 1, 0, 0)));
    tbl_a.push_back(mk(0, 0, 1, 320, ex(PLAY,  1, 1, 0, 0)));
    tbl_a.push_back(mk(0, 1, 0, 320, ex(PAUSE, 1, 1, 0, 0)));

    // Enemy reaches WIN_SCORE, then a restart clears the scores.
    tbl_b.push_back(mk(1, 0, 0, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_b.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_b.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 0, 0, 0)));
    tbl_b.push_back(mk(0, 0, 1, 320, ex(PLAY,  0, 0, 0, 0)));
    tbl_b.push_back(mk(0, 0, 1, 641, ex(POINT, 0, 0, 0, 0)));
    tbl_b.push_back(mk(0, 0, 0, 320, ex(SERVE, 0, 1, 1, 0)));
    tbl_b.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 1, 1, 0)));
    tbl_b.push_back(mk(0, 0, 1, 320, ex(SERVE, 0, 1, 1, 0)));
    tbl_b.push_back(mk(0, 0, 1, 320, ex(PLAY,  0, 1, 1, 0)));
    tbl_b.push_back(mk(0, 0, 1, 641, ex(POINT, 0, 1, 1, 0)));
    tbl_b.push_back(mk(0, 0, 0, 320, ex(OVER,  0, 2, 1, 1)));
    tbl_b.push_back(mk(1, 0, 0, 320, ex(SERVE, 0, 0, 0, 0)));

    do_reset();
    check("reset", ex(IDLE, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      step($sformatf("idle_frame%0d", i), mk(0, 0, 1, 320, ex(IDLE, 0, 0, 0, 0)));

    // Start held for 20 cycles with frames running: single serve, then PLAY.
    serve_entries = 0;
    prev_st = state_o;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("hold_start%0d", i),
           mk(1, 0, 1, 320, ex((i < 3) ? SERVE : PLAY, 0, 0, 0, 0)));
      if (state_o == 3'(SERVE) && prev_st != 3'(SERVE)) serve_entries++;
      prev_st = state_o;
    end
    n_vec++;
    if (serve_entries != 1) begin
      n_bad++;
      $display("FAIL serve_entries: got %0d want 1", serve_entries);
    end

    do_reset();
    foreach (tbl_a[i]) step($sformatf("a%0d", i), tbl_a[i]);

    // Asynchronous reset mid-cycle while paused at 1/1.
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset", ex(IDLE, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step("post_reset", mk(0, 0, 0, 320, ex(IDLE, 0, 0, 0, 0)));

    foreach (tbl_b[i]) step($sformatf("b%0d", i), tbl_b[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
